// File: rtl/crc16_pkg.sv
// Shared constants and FSM encoding for the CRC-16 checker and generator.
// Both sides must agree on polynomial, seed and residue, so they live here.
package crc16_pkg;

  localparam logic [15:0] POLY          = 16'h1021;
  localparam logic [15:0] INIT          = 16'hFFFF;
  localparam logic [15:0] RESIDUE       = 16'h0000;
  localparam logic [15:0] MIN_FRAME_LEN = 16'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/crc16_checker_if.sv
// Byte stream in, CRC status out; the source drives through master,
// and the checker sits on slave.
interface crc16_checker_if;

  logic [7:0]  data_in;
  logic        data_valid;
  logic        frame_start;
  logic        frame_end;
  logic [15:0] crc_out;
  logic [15:0] byte_count;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;
  logic        abort;

  modport master (
    output data_in, data_valid, frame_start, frame_end,
    input  crc_out, byte_count, done, crc_ok, crc_err, len_err, abort
  );

  modport slave (
    input  data_in, data_valid, frame_start, frame_end,
    output crc_out, byte_count, done, crc_ok, crc_err, len_err, abort
  );

endinterface

// File: rtl/crc16_byte_update.sv
// Combinational CRC-16 step over one byte, MSB first, non-reflected.
// Eight serial shift/XOR iterations unrolled into a single cycle.
module crc16_byte_update #(
  parameter logic [15:0] POLY = crc16_pkg::POLY
) (
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data_i[i]) begin
        c = {c[14:0], 1'b0} ^ POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc16_checker.sv
// Frame CRC-16 checker: absorbs payload plus trailing CRC bytes and reports
// good/bad/short status one cycle after the last byte.
module crc16_checker #(
  parameter logic [15:0] POLY = crc16_pkg::POLY,
  parameter logic [15:0] INIT = crc16_pkg::INIT
) (
  input  logic           clk,
  input  logic           rst,
  crc16_checker_if.slave bus
);

  import crc16_pkg::*;

  state_e      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        len_q, len_d;
  logic        abort_q, abort_d;
  logic [15:0] crc_run;
  logic [15:0] crc_first;
  logic        take_start;

  crc16_byte_update #(.POLY(POLY)) u_run (
    .crc_i  (crc_q),
    .data_i (bus.data_in),
    .crc_o  (crc_run)
  );

  // A frame_start byte always seeds from INIT, whatever the register holds.
  crc16_byte_update #(.POLY(POLY)) u_first (
    .crc_i  (INIT),
    .data_i (bus.data_in),
    .crc_o  (crc_first)
  );

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Returns {len_err, crc_ok, crc_err}; exactly one bit is set.
  function automatic logic [2:0] frame_status(input logic [15:0] cnt,
                                              input logic [15:0] crc);
    logic short_f;
    logic good_f;
    short_f = (cnt < MIN_FRAME_LEN);
    good_f  = !short_f && (crc == RESIDUE);
    return {short_f, good_f, !short_f && !good_f};
  endfunction

  assign take_start = bus.data_valid && bus.frame_start;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    err_d   = err_q;
    len_d   = len_q;
    abort_d = 1'b0;

    if (take_start) begin
      abort_d = (state_q == RECV);
      crc_d   = crc_first;
      cnt_d   = 16'd1;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      len_d   = 1'b0;
      state_d = RECV;
      if (bus.frame_end) begin
        state_d               = DONE;
        {len_d, ok_d, err_d}  = frame_status(16'd1, crc_first);
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RECV: begin
          if (bus.data_valid) begin
            crc_d = crc_run;
            cnt_d = sat_inc(cnt_q);
            if (bus.frame_end) begin
              state_d              = DONE;
              {len_d, ok_d, err_d} = frame_status(cnt_d, crc_d);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      cnt_q   <= 16'd0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      len_q   <= len_d;
      abort_q <= abort_d;
    end
  end

  assign bus.crc_out    = crc_q;
  assign bus.byte_count = cnt_q;
  assign bus.done       = (state_q == DONE);
  assign bus.crc_ok     = ok_q;
  assign bus.crc_err    = err_q;
  assign bus.len_err    = len_q;
  assign bus.abort      = abort_q;

endmodule
